sha3_pad_block: RTL and testbench
=================================

Name: sha3_pad_block

Overview:
- Parametrised successor to the fixed 16-bit SHA-3 padder.
- Accepts a message as an AXI-Stream of DATA_W-bit beats and packs the bytes into RATE_BITS-wide rate blocks.
- Applies the domain suffix and pad10*1 on the final block, and presents each completed block to the absorb stage with a valid/ready handshake.
- Sits between the input stream interface and the Keccak-f permutation core.

Parameters:
- DATA_W, 64, input beat width in bits; multiple of 8. BYTES = DATA_W/8.
- RATE_BITS, 1088, rate block width in bits. RATE_BYTES = RATE_BITS/8. RATE_BYTES must be a multiple of BYTES.
- DSUFFIX, 8'h06, domain-separation byte (06 for SHA3, 1F for SHAKE).

Ports:
- ACLK  in  1  clock, rising edge.
- ARESETn  in  1  synchronous active-low reset.
- s_tdata  in  DATA_W  message bytes; byte j = s_tdata[8j+7:8j].
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accepted when s_tvalid&s_tready.
- s_tlast  in  1  final beat of message.
- s_tuser  in  $clog2(BYTES+1)  valid-byte count on the last beat (0..BYTES).
- m_block  out  RATE_BITS  rate block; block byte i = m_block[8i+7:8i].
- m_valid  out  1  block valid.
- m_ready  in  1  block consumed when m_valid&m_ready.
- m_last  out  1  current block is the final (padded) block of the message.

Behaviour:
- Reset (ARESETn=0 at a rising edge): state FILL, byte pointer ptr=0, buffer=0, pad_pending=0, m_valid=0, m_last=0.
  - s_tready=0 while ARESETn is low; s_tready=1 in the first cycle after release.
  - Reset mid-message discards all partial data.
- Beat rules:
  - Non-last beat: all BYTES bytes are valid; s_tuser is ignored.
  - Last beat: the low s_tuser bytes are valid; bytes above the count are ignored.
  - s_tuser > BYTES saturates to BYTES.
  - s_tuser=0 is legal only with s_tlast (empty tail / empty message).
- Accepted beat: valid bytes are written to buffer bytes ptr..ptr+n-1; ptr += n.
- State FILL (s_tready=1, m_valid=0):
  - Non-last beat with ptr+BYTES == RATE_BYTES -> FULL.
  - Last beat with ptr+n < RATE_BYTES -> buffer byte (ptr+n) ^= DSUFFIX, byte RATE_BYTES-1 ^= 0x80, then go to FINAL.
    - If ptr+n == RATE_BYTES-1, both XORs hit the same byte (0x86 for SHA3).
  - Last beat with ptr+n == RATE_BYTES -> FULL, pad_pending=1.
- State FULL (m_valid=1, m_last=0, s_tready=0):
  - On m_ready, the buffer clears and ptr=0.
  - If pad_pending: load the pad-only block (byte0=DSUFFIX, byte RATE_BYTES-1=0x80), clear pad_pending, go to FINAL.
  - Otherwise go to FILL.
- State FINAL (m_valid=1, m_last=1, s_tready=0): on m_ready, the buffer clears, ptr=0, go to FILL.
- Latency: m_valid rises the cycle after the beat that completes or terminates a block is accepted.
  - The pad-only block appears the cycle after the FULL handshake.
- Stability: m_block and m_last are stable while m_valid=1 and m_ready=0.
  - Output is registered; no combinational path from m_ready to m_block.
- Buffer bytes never written by message data or padding are 0.
- The next message may start in the cycle after a FINAL handshake.
  - Worst-case throughput per block: RATE_BYTES/BYTES beats + 1 handshake cycle.
- No overlap: no beat is accepted while a block is pending.

Test Plan (DATA_W=64, RATE_BITS=1088, DSUFFIX=06):
- Empty message: one beat, s_tlast=1, s_tuser=0 -> one block with byte0=06, byte135=80, all other bytes 00, m_last=1.
- "abc": s_tdata=64'h636261, s_tuser=3, s_tlast=1 -> bytes0..3 = 61 62 63 06, byte135=80, m_last=1, m_valid high the cycle after the beat.
- 135-byte message (16 full beats + last beat with s_tuser=7) -> single block, byte134 = last data byte, byte135=86, m_last=1.
- 136-byte message (17 full beats, last s_tuser=8) -> block1 holds the data with m_last=0; after its handshake, block2 has byte0=06, byte135=80, rest 00, m_last=1.
- Backpressure: m_ready=0 for 10 cycles while m_valid=1 -> m_block constant and s_tready=0 throughout; two back-to-back messages produce both correct blocks with no beat lost.
- Reset mid-message: ARESETn=0 for 1 cycle after 5 beats, then send "abc" -> the output equals the "abc" case exactly, with no residual bytes.

Source files
------------

// File: rtl/sha3_pad_block.sv
// SHA-3 padder: packs AXI-Stream message beats into RATE_BITS rate blocks,
// applies the domain suffix and pad10*1, and hands blocks to the absorb stage.
module sha3_pad_block #(
    parameter int          DATA_W    = 64,
    parameter int          RATE_BITS = 1088,
    parameter logic [7:0]  DSUFFIX   = 8'h06
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [DATA_W-1:0]                 s_tdata,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    input  logic                              s_tlast,
    input  logic [$clog2(DATA_W/8+1)-1:0]     s_tuser,
    output logic [RATE_BITS-1:0]              m_block,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last
);

    localparam int BYTES      = DATA_W / 8;
    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int USER_W     = $clog2(BYTES + 1);
    localparam int PTR_W      = $clog2(RATE_BYTES + 1);

    typedef enum logic [1:0] {FILL, FULL, FINAL} state_t;

    state_t                state_q, state_n;
    logic [PTR_W-1:0]      ptr_q, ptr_n, fill;
    logic [RATE_BITS-1:0]  buf_q, buf_n, data_vec, pad_vec, pad_only;
    logic                  pad_q, pad_n;
    logic [USER_W-1:0]     nbytes;
    logic [DATA_W-1:0]     data_m;
    logic                  beat;

    assign s_tready = ARESETn && (state_q == FILL);
    assign m_valid  = (state_q != FILL);
    assign m_last   = (state_q == FINAL);
    assign m_block  = buf_q;
    assign beat     = s_tvalid && s_tready;

    // Valid-byte count, masked beat placed at ptr, and the pad10*1 pattern
    // positioned right after the last message byte.
    always_comb begin
        if (!s_tlast)                     nbytes = USER_W'(BYTES);
        else if (s_tuser > USER_W'(BYTES)) nbytes = USER_W'(BYTES);
        else                               nbytes = s_tuser;
        fill     = ptr_q + PTR_W'(nbytes);
        data_m   = s_tdata & ~({DATA_W{1'b1}} << {nbytes, 3'b000});
        data_vec = RATE_BITS'(data_m) << {ptr_q, 3'b000};
        pad_only = RATE_BITS'(DSUFFIX) ^ {8'h80, {(RATE_BITS-8){1'b0}}};
        pad_vec  = (RATE_BITS'(DSUFFIX) << {fill, 3'b000}) ^ {8'h80, {(RATE_BITS-8){1'b0}}};
    end

    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        buf_n   = buf_q;
        pad_n   = pad_q;
        unique case (state_q)
            FILL: begin
                if (beat) begin
                    buf_n = buf_q | data_vec;
                    ptr_n = fill;
                    if (fill == PTR_W'(RATE_BYTES)) begin
                        state_n = FULL;
                        pad_n   = s_tlast;
                    end else if (s_tlast) begin
                        buf_n   = (buf_q | data_vec) ^ pad_vec;
                        state_n = FINAL;
                    end
                end
            end
            FULL: begin
                if (m_ready) begin
                    ptr_n = '0;
                    pad_n = 1'b0;
                    if (pad_q) begin
                        buf_n   = pad_only;
                        state_n = FINAL;
                    end else begin
                        buf_n   = '0;
                        state_n = FILL;
                    end
                end
            end
            FINAL: begin
                if (m_ready) begin
                    buf_n   = '0;
                    ptr_n   = '0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values. The buffer is reset too: its unwritten bytes must read 0.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= FILL;
            ptr_q   <= '0;
            buf_q   <= '0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            buf_q   <= buf_n;
            pad_q   <= pad_n;
        end
    end

endmodule

// File: tb/tb_sha3_pad_block.sv
// Scoreboard bench for sha3_pad_block: random messages are padded by a byte-level
// reference model, and a monitor compares every block handed over by the DUT.
module tb_sha3_pad_block;

    localparam int         DATA_W    = 64;
    localparam int         RATE_BITS = 1088;
    localparam logic [7:0] DSUFFIX   = 8'h06;
    localparam int         BYTES     = DATA_W / 8;
    localparam int         RB        = RATE_BITS / 8;
    localparam int         USER_W    = $clog2(BYTES + 1);

    logic                 ACLK = 1'b0;
    logic                 ARESETn = 1'b0;
    logic [DATA_W-1:0]    s_tdata = '0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tready;
    logic                 s_tlast = 1'b0;
    logic [USER_W-1:0]    s_tuser = '0;
    logic [RATE_BITS-1:0] m_block;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic                 m_last;

    typedef struct {
        logic [RATE_BITS-1:0] blk;
        logic                 last;
    } blk_t;

    blk_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ready_mode = 2;   // 0 random, 1 held low, 2 held high
    bit   mon_en = 1'b0;
    int   blk_no = 0;

    sha3_pad_block #(.DATA_W(DATA_W), .RATE_BITS(RATE_BITS), .DSUFFIX(DSUFFIX)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_block(m_block), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] get_byte(input logic [RATE_BITS-1:0] v, input int i);
        return 8'(v >> (i * 8));
    endfunction

    // Reference: append suffix, pad with zeros to a whole number of rate blocks
    // (always at least one pad byte), set the top bit of the final byte.
    function automatic void push_model(input byte unsigned msg[$]);
        int           len   = msg.size();
        int           total = (len / RB + 1) * RB;
        byte unsigned pad[];
        pad = new[total];
        foreach (pad[k]) pad[k] = 8'h00;
        foreach (msg[k]) pad[k] = msg[k];
        pad[len]       = pad[len] ^ DSUFFIX;
        pad[total - 1] = pad[total - 1] ^ 8'h80;
        for (int b = 0; b < total / RB; b++) begin
            blk_t e;
            e.blk = '0;
            for (int k = 0; k < RB; k++)
                e.blk = e.blk | (RATE_BITS'(pad[b * RB + k]) << (k * 8));
            e.last = (b == total / RB - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic last, input logic [USER_W-1:0] user);
        int waited = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        forever begin
            @(negedge ACLK);
            if (s_tready) begin
                @(posedge ACLK);
                #1;
                break;
            end
            waited++;
            if (waited > 3000) begin
                check("beat_accept_timeout", 64'(s_tready), 64'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle_maybe();
        if ($urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge ACLK);
            #1;
        end
    endtask

    // Sends len random bytes; if empty_tail and len is a non-zero multiple of BYTES,
    // the message ends with an extra zero-byte last beat.
    task automatic send_msg(input int len, input bit empty_tail);
        byte unsigned msg[$];
        int           idx = 0;
        int           rem;
        logic [63:0]  d;
        logic [USER_W-1:0] u;
        for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
        push_model(msg);
        rem = len;
        while (rem > BYTES || (rem == BYTES && empty_tail)) begin
            d = '0;
            for (int j = 0; j < BYTES; j++) d = d | (64'(msg[idx + j]) << (j * 8));
            send_beat(d, 1'b0, USER_W'($urandom));
            idx += BYTES;
            rem -= BYTES;
            idle_maybe();
        end
        d = {$urandom, $urandom};
        for (int j = 0; j < rem; j++) begin
            d = d & ~(64'hFF << (j * 8));
            d = d | (64'(msg[idx + j]) << (j * 8));
        end
        u = USER_W'(rem);
        if (rem == BYTES && $urandom_range(0, 1) == 1) u = USER_W'($urandom_range(BYTES, 2**USER_W - 1));
        send_beat(d, 1'b1, u);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(posedge ACLK);
            w++;
        end
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Sink-side ready generator, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            case (ready_mode)
                0:       m_ready = 1'($urandom_range(0, 1));
                1:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Monitor: checks stability while stalled and pops the scoreboard per handshake.
    initial begin
        logic [RATE_BITS-1:0] hold_blk;
        logic                 hold_last;
        bit                   holding = 1'b0;
        blk_t                 e;
        int                   idx;
        hold_blk  = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn || !mon_en || !m_valid) begin
                holding = 1'b0;
                continue;
            end
            check("no_beat_while_pending", 64'(s_tready), 64'd0);
            if (holding) begin
                check("stable_block", 64'(m_block === hold_blk), 64'd1);
                check("stable_last", 64'(m_last), 64'(hold_last));
            end
            if (m_ready) begin
                holding = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_block", 64'(m_valid), 64'd0);
                end else begin
                    e   = exp_q.pop_front();
                    idx = 0;
                    for (int k = RB - 1; k >= 0; k--)
                        if (get_byte(m_block, k) !== get_byte(e.blk, k)) idx = k;
                    check($sformatf("block%0d_byte%0d", blk_no, idx),
                          64'(get_byte(m_block, idx)), 64'(get_byte(e.blk, idx)));
                    check($sformatf("block%0d_last", blk_no), 64'(m_last), 64'(e.last));
                    blk_no++;
                end
            end else begin
                holding   = 1'b1;
                hold_blk  = m_block;
                hold_last = m_last;
            end
        end
    end

    initial begin
        logic [RATE_BITS-1:0] saved;
        byte unsigned         abc[$];
        abc = '{8'h61, 8'h62, 8'h63};

        repeat (3) @(posedge ACLK);
        #1;
        check("reset_tready", 64'(s_tready), 64'd0);
        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_last", 64'(m_last), 64'd0);
        check("reset_block_lo", m_block[63:0], 64'd0);
        check("reset_block_hi", m_block[RATE_BITS-1 -: 64], 64'd0);
        ARESETn = 1'b1;
        #1;
        check("tready_after_release", 64'(s_tready), 64'd1);
        mon_en = 1'b1;

        // "abc" with the sink stalled: latency, contents and stability under backpressure.
        ready_mode = 1;
        @(posedge ACLK);
        #1;
        push_model(abc);
        send_beat(64'h636261, 1'b1, USER_W'(3));
        check("abc_valid_next_cycle", 64'(m_valid), 64'd1);
        check("abc_last", 64'(m_last), 64'd1);
        check("abc_low_bytes", m_block[63:0], 64'h0000_0000_0663_6261);
        check("abc_byte135", 64'(get_byte(m_block, RB - 1)), 64'h80);
        saved = m_block;
        for (int c = 0; c < 10; c++) begin
            @(posedge ACLK);
            #1;
            check("bp_tready_low", 64'(s_tready), 64'd0);
            check("bp_block_const", 64'(m_block === saved), 64'd1);
        end
        ready_mode = 2;
        drain();

        send_msg(0, 1'b0);
        send_msg(135, 1'b0);
        send_msg(136, 1'b0);
        send_msg(136, 1'b1);
        drain();

        ready_mode = 0;
        for (int m = 0; m < 12; m++) send_msg($urandom_range(0, 300), 1'($urandom_range(0, 1)));
        send_msg(271, 1'b0);
        send_msg(272, 1'b0);
        ready_mode = 2;
        drain();

        // Reset in the middle of a message: partial data must vanish.
        for (int b = 0; b < 5; b++) send_beat({$urandom, $urandom}, 1'b0, '0);
        ARESETn  = 1'b0;
        s_tvalid = 1'b0;
        @(posedge ACLK);
        #1;
        check("midreset_tready", 64'(s_tready), 64'd0);
        check("midreset_valid", 64'(m_valid), 64'd0);
        ARESETn = 1'b1;
        #1;
        check("midreset_tready_release", 64'(s_tready), 64'd1);
        check("midreset_buffer_clear", m_block[63:0], 64'd0);
        push_model(abc);
        send_beat(64'h636261, 1'b1, USER_W'(3));
        check("post_reset_abc_low", m_block[63:0], 64'h0000_0000_0663_6261);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
